// File: rtl/am_search_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : am_search_pkg
//  Brief    : Shared HDC package. Holds the encoding constants and the
//             associative-memory search sizing, widths and FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package am_search_pkg;

   // Encoding-side constants shared with the hypervector encoder
   localparam int ENC_NGRAM   = 3;
   localparam int ENC_LEVELS  = 16;

   // Associative-memory search sizing
   localparam int HV_DIM      = 64;
   localparam int DIMS_PER_CC = 16;
   localparam int CLASS_COUNT = 4;
   localparam int CHUNKS      = HV_DIM / DIMS_PER_CC;

   // ceil(log2(n)) but never less than one bit
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CLASS_W     = clog2_min1(CLASS_COUNT);
   localparam int SCORE_W     = $clog2(HV_DIM + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_DONE   = 2'd3
   } am_state_t;

endpackage
`default_nettype wire

// File: rtl/am_search_if.sv
`default_nettype none
// ============================================================================
//  Module   : am_search_if
//  Brief    : Request/result bundle of the associative-memory search.
//             master = requester (drives query and prototypes),
//             slave  = am_search.
//  Revision : 1.0 - initial release
// ============================================================================
interface am_search_if #(
   parameter int HV_DIM      = am_search_pkg::HV_DIM,
   parameter int CLASS_COUNT = am_search_pkg::CLASS_COUNT
) ();
   localparam int CLASS_W = am_search_pkg::clog2_min1(CLASS_COUNT);
   localparam int SCORE_W = $clog2(HV_DIM + 1);

   logic                start_search;
   logic [HV_DIM-1:0]   query_hv;
   logic [HV_DIM-1:0]   class_hvs [0:CLASS_COUNT-1];
   logic                search_done;
   logic [CLASS_W-1:0]  predicted_class;
   logic [SCORE_W-1:0]  best_score;

   modport master (
      output start_search, query_hv, class_hvs,
      input  search_done, predicted_class, best_score
   );

   modport slave (
      input  start_search, query_hv, class_hvs,
      output search_done, predicted_class, best_score
   );
endinterface
`default_nettype wire

// File: rtl/am_popcount.sv
`default_nettype none
// ============================================================================
//  Module   : am_popcount
//  Brief    : Combinational AND-popcount of two equal-width slices.
//  Revision : 1.0 - initial release
// ============================================================================
module am_popcount #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   output logic      [CNT_W-1:0] count
);

   // Count the positions where both slices are set
   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + CNT_W'(a[i] & b[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/am_search.sv
`default_nettype none
// ============================================================================
//  Module   : am_search
//  Brief    : Associative-memory search. Accumulates the overlap score of a
//             latched query against every class prototype DIMS_PER_CC bits
//             per cycle, then scans the scores for the lowest-index maximum.
//  Revision : 1.0 - initial release
// ============================================================================
module am_search
   import am_search_pkg::*;
#(
   parameter int HV_DIM      = am_search_pkg::HV_DIM,
   parameter int DIMS_PER_CC = am_search_pkg::DIMS_PER_CC,
   parameter int CLASS_COUNT = am_search_pkg::CLASS_COUNT
) (
   input  wire logic   clk,
   input  wire logic   nrst,
   input  wire logic   en,
   am_search_if.slave  bus
);

   localparam int N_CHUNKS = HV_DIM / DIMS_PER_CC;
   localparam int CHUNK_W  = clog2_min1(N_CHUNKS);
   localparam int CLS_W    = clog2_min1(CLASS_COUNT);
   localparam int SCR_W    = $clog2(HV_DIM + 1);
   localparam int PC_W     = $clog2(DIMS_PER_CC + 1);

   localparam logic [CHUNK_W-1:0] c_last_chunk = CHUNK_W'(N_CHUNKS - 1);
   localparam logic [CLS_W-1:0]   c_last_class = CLS_W'(CLASS_COUNT - 1);

   am_state_t           r_state;
   logic [HV_DIM-1:0]   r_query;
   logic [CHUNK_W-1:0]  r_chunk;
   logic [CLS_W-1:0]    r_idx;
   logic [SCR_W-1:0]    r_acc [0:CLASS_COUNT-1];
   logic [SCR_W-1:0]    r_run_best;
   logic [CLS_W-1:0]    r_run_idx;
   logic                r_search_done;
   logic [CLS_W-1:0]    r_predicted;
   logic [SCR_W-1:0]    r_best_score;

   logic [DIMS_PER_CC-1:0] w_q_chunk;
   logic [PC_W-1:0]        w_pc [0:CLASS_COUNT-1];
   logic [SCR_W-1:0]       w_cand;
   logic                   w_take;
   logic [SCR_W-1:0]       w_new_best;
   logic [CLS_W-1:0]       w_new_idx;

   // Current chunk of the latched query
   always_comb begin
      w_q_chunk = r_query[int'(r_chunk) * DIMS_PER_CC +: DIMS_PER_CC];
   end

   // One AND-popcount per class prototype on the current chunk
   for (genvar c = 0; c < CLASS_COUNT; c++) begin : g_pop
      logic [DIMS_PER_CC-1:0] w_cls_chunk;
      assign w_cls_chunk = bus.class_hvs[c][int'(r_chunk) * DIMS_PER_CC +: DIMS_PER_CC];

      am_popcount #(
         .WIDTH (DIMS_PER_CC),
         .CNT_W (PC_W)
      ) u_pop (
         .a     (w_q_chunk),
         .b     (w_cls_chunk),
         .count (w_pc[c])
      );
   end

   // Argmax step: index 0 seeds the running best, later indices win only
   // on a strictly larger score so ties keep the lowest index
   always_comb begin
      w_cand     = r_acc[r_idx];
      w_take     = (r_idx == '0) || (w_cand > r_run_best);
      w_new_best = w_take ? w_cand : r_run_best;
      w_new_idx  = w_take ? r_idx  : r_run_idx;
   end

   // Search FSM with accumulators, argmax scan and registered results
   always_ff @(posedge clk) begin
      if (nrst) begin
         r_state       <= ST_IDLE;
         r_query       <= '0;
         r_chunk       <= '0;
         r_idx         <= '0;
         r_run_best    <= '0;
         r_run_idx     <= '0;
         r_search_done <= 1'b0;
         r_predicted   <= '0;
         r_best_score  <= '0;
         for (int c = 0; c < CLASS_COUNT; c++) begin
            r_acc[c] <= '0;
         end
      end else if (en) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start_search) begin
                  r_query <= bus.query_hv;
                  r_chunk <= '0;
                  for (int c = 0; c < CLASS_COUNT; c++) begin
                     r_acc[c] <= '0;
                  end
                  r_state <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               for (int c = 0; c < CLASS_COUNT; c++) begin
                  r_acc[c] <= r_acc[c] + SCR_W'(w_pc[c]);
               end
               r_chunk <= r_chunk + 1'b1;
               if (r_chunk == c_last_chunk) begin
                  r_idx   <= '0;
                  r_state <= ST_ARGMAX;
               end
            end
            ST_ARGMAX: begin
               r_run_best <= w_new_best;
               r_run_idx  <= w_new_idx;
               r_idx      <= r_idx + 1'b1;
               if (r_idx == c_last_class) begin
                  r_predicted   <= w_new_idx;
                  r_best_score  <= w_new_best;
                  r_search_done <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_search_done <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_search_done <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.search_done     = r_search_done;
   assign bus.predicted_class = r_predicted;
   assign bus.best_score      = r_best_score;

endmodule
`default_nettype wire

// File: doc/am_search.md
AM_SEARCH -- requirements
Module: am_search

Interface
REQ-001 SHALL take parameter HV_DIM, default from shared package, meaning hypervector width in bits.
REQ-002 SHALL take parameter DIMS_PER_CC, default from shared package, meaning dimensions processed per clock; HV_DIM SHALL be a multiple of it.
REQ-003 SHALL take parameter CLASS_COUNT, default from shared package, meaning number of class prototype hypervectors (>=2).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 nrst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  global enable; when 0, all state holds.
REQ-008 start_search  input  1  request to classify query_hv; sampled only in IDLE with en=1.
REQ-009 query_hv  input  HV_DIM  encoded query hypervector, the encoding block's encoded_hv; sampled with start_search.
REQ-010 class_hvs  input  HV_DIM x CLASS_COUNT (unpacked [0:CLASS_COUNT-1])  class prototypes; caller SHALL hold them stable from start until search_done.
REQ-011 search_done  output  1  single-cycle pulse when the result is valid.
REQ-012 predicted_class  output  CLASS_W  index of best-matching class; CLASS_W = max(1, clog2(CLASS_COUNT)).
REQ-013 best_score  output  SCORE_W  overlap score of predicted_class; SCORE_W = clog2(HV_DIM+1).

Function
REQ-014 Similarity SHALL be overlap: score[c] = popcount(query AND class_hvs[c]) over all HV_DIM bits.
REQ-015 FSM states SHALL be IDLE, ACCUM, ARGMAX, DONE.
REQ-016 IDLE: start_search=1 and en=1 latches query_hv into a query register, clears all CLASS_COUNT accumulators and chunk counter, next state ACCUM.
REQ-017 ACCUM: each enabled cycle, chunk k = bits [k*DIMS_PER_CC +: DIMS_PER_CC] of latched query and each class is ANDed, popcounted and added to that class's SCORE_W accumulator; k increments from 0 to CHUNKS-1 (CHUNKS = HV_DIM/DIMS_PER_CC), after k=CHUNKS-1 next state ARGMAX.
REQ-018 Accumulators SHALL NOT overflow: SCORE_W holds HV_DIM exactly; no saturation logic.
REQ-019 ARGMAX: sequential scan, one class per enabled cycle, index 0 to CLASS_COUNT-1; running best initialised to class 0; class i replaces best only if score[i] > best (strict), so ties resolve to lowest index.
REQ-020 After scanning index CLASS_COUNT-1, predicted_class/best_score registers SHALL update, next state DONE.
REQ-021 DONE: search_done=1 for exactly one cycle, next state IDLE; search_done=0 in every other state.
REQ-022 Latency: start sampled at edge t -> search_done high in the cycle after edge t+CHUNKS+CLASS_COUNT, absent en stalls; each en=0 cycle adds one cycle.
REQ-023 start_search outside IDLE SHALL be ignored (no restart, no queueing); start in DONE cycle is ignored.
REQ-024 predicted_class and best_score SHALL hold their last value until the next search completes.
REQ-025 en=0 in any state SHALL freeze counter, accumulators, FSM and outputs; a pending search_done pulse is held until en returns.

Reset
REQ-026 nrst=1 SHALL force state IDLE, chunk and class counters 0, accumulators 0, query register 0, search_done 0, predicted_class 0, best_score 0, regardless of en.
REQ-027 Reset mid-search SHALL abort without a search_done pulse; the next start after reset runs a full, clean search.

Structure
REQ-028 HV_DIM, DIMS_PER_CC, CLASS_COUNT, CHUNKS, CLASS_W, SCORE_W and the FSM state enum SHALL live in the shared HDC package alongside the encoding constants.
REQ-029 A sub-module am_popcount (DIMS_PER_CC-bit AND-popcount, combinational, output clog2(DIMS_PER_CC+1) bits) SHALL be instantiated CLASS_COUNT times.

Verification (bench params HV_DIM=64, DIMS_PER_CC=16, CLASS_COUNT=4, CHUNKS=4)
REQ-030 query=class_hvs[2]=64'hFFFF_0000_FFFF_0000, other classes 64'h0000_FFFF_0000_FFFF -> search_done 9 cycles after start edge, predicted_class=2, best_score=32.
REQ-031 Tie: class1 and class3 both overlap 10 bits, class0=5, class2=0 -> predicted_class=1, best_score=10.
REQ-032 query all-zero -> predicted_class=0, best_score=0, single search_done pulse.
REQ-033 en=0 for 3 cycles during ACCUM -> search_done at 12 cycles after start, result identical to REQ-030.
REQ-034 nrst=1 during ARGMAX -> no search_done, outputs 0; new start then completes normally; start_search pulsed mid-ACCUM -> ignored, exactly one search_done.
